// File: rtl/board_check_seq.sv
// board_check_seq: CHECKING-phase sequencer for the Sudoku board.
// Walks the 81-cell board RAM as 27 groups (9 rows, 9 columns, 9 boxes),
// one read per clock. Each group must hold exactly the values 1..9.
// The walk stops at the first failing group and reports done/solved.
//
// Read handshake: rd_en high in a cycle issues a read of rd_addr.
// rd_data carries that cell in the following cycle, with a fixed latency of
// one cycle and no backpressure. The group/cell tag of each issued read is
// registered alongside it, so the check stage knows which group the returned
// word belongs to.
module board_check_seq #(
  parameter int SIDE   = 9,
  parameter int BOX    = 3,
  parameter int ADDR_W = 7,
  parameter int VAL_W  = 4
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              check_flag,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [VAL_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              solved,
  output logic [4:0]        err_group,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  localparam logic [4:0] LAST_G = 5'(3 * SIDE - 1);
  localparam logic [3:0] LAST_K = 4'(SIDE - 1);

  logic [1:0]      state_q, state_d;
  logic [4:0]      g_q, g_d;
  logic [3:0]      k_q, k_d;
  logic [SIDE-1:0] seen_q, seen_d;
  logic            pend_q, pend_d;   // a read was issued last cycle
  logic            first_q, first_d; // that read was cell 0 of its group
  logic [4:0]      tag_q, tag_d;     // group of that read
  logic            solved_q, solved_d;
  logic [4:0]      err_q, err_d;

  logic [3:0]      row, col;
  logic [4:0]      b;
  logic [SIDE-1:0] mask_eff, onehot;
  logic            val_ok, chk_en, bad, fail;

  assign b = g_q - 5'd18;

  // Map the (group, cell) counters to a board row/column.
  always_comb begin
    row = '0;
    col = '0;
    if (g_q < 5'd9) begin
      row = g_q[3:0];
      col = k_q;
    end else if (g_q < 5'd18) begin
      row = k_q;
      col = 4'(g_q - 5'd9);
    end else begin
      row = 4'((b / BOX) * BOX + k_q / BOX);
      col = 4'((b % BOX) * BOX + k_q % BOX);
    end
  end

  // Check stage: the first cell of a group sees an empty mask, which removes
  // the need for a bubble between groups.
  assign mask_eff = first_q ? '0 : seen_q;
  assign val_ok   = (rd_data != '0) && (rd_data <= VAL_W'(SIDE));
  assign onehot   = val_ok ? (SIDE'(1) << (rd_data - VAL_W'(1))) : '0;
  assign chk_en   = pend_q && ((state_q == SCAN) || (state_q == DRAIN));
  assign bad      = !val_ok || ((mask_eff & onehot) != '0);
  assign fail     = chk_en && bad;

  // Next-state logic for the FSM, counters, check pipeline and results.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    k_d      = k_q;
    seen_d   = seen_q;
    pend_d   = pend_q;
    first_d  = first_q;
    tag_d    = tag_q;
    solved_d = solved_q;
    err_d    = err_q;

    if (chk_en && !bad) begin
      seen_d = mask_eff | onehot;
    end

    case (state_q)
      IDLE: begin
        if (check_flag) begin
          state_d  = SCAN;
          g_d      = '0;
          k_d      = '0;
          seen_d   = '0;
          pend_d   = 1'b0;
          solved_d = 1'b0;
          err_d    = '0;
        end
      end
      SCAN: begin
        pend_d  = !fail;
        tag_d   = g_q;
        first_d = (k_q == '0);
        if (fail) begin
          state_d = REPORT;
          err_d   = tag_q;
          pend_d  = 1'b0;
        end else if (k_q == LAST_K) begin
          k_d = '0;
          if (g_q == LAST_G) begin
            state_d = DRAIN;
          end else begin
            g_d = g_q + 5'd1;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DRAIN: begin
        pend_d  = 1'b0;
        state_d = REPORT;
        if (fail) begin
          err_d = tag_q;
        end else begin
          solved_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q  <= IDLE;
      g_q      <= '0;
      k_q      <= '0;
      seen_q   <= '0;
      pend_q   <= 1'b0;
      first_q  <= 1'b0;
      tag_q    <= '0;
      solved_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      k_q      <= k_d;
      seen_q   <= seen_d;
      pend_q   <= pend_d;
      first_q  <= first_d;
      tag_q    <= tag_d;
      solved_q <= solved_d;
      err_q    <= err_d;
    end
  end

  // A failure seen this cycle suppresses the read that would follow it.
  assign rd_en     = (state_q == SCAN) && !fail;
  assign rd_addr   = (state_q == SCAN) ? ADDR_W'(row * SIDE + col) : '0;
  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign done      = (state_q == REPORT);
  assign solved    = solved_q;
  assign err_group = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_board_check_seq.sv
// Bench for board_check_seq: board RAM model, reference checker, scoreboard.
module tb_board_check_seq;

  logic       clka = 1'b0;
  logic       restart_n;
  logic       check_flag;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [3:0] rd_data;
  logic       busy, done, solved;
  logic [4:0] err_group;
  logic [1:0] dbg_state;

  board_check_seq dut (
    .clka(clka), .restart_n(restart_n), .check_flag(check_flag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .solved(solved), .err_group(err_group),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clka = ~clka;
  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // board RAM with one-cycle read latency; junk on idle cycles
  logic [3:0] board [81];
  always @(posedge clka)
    rd_data <= (rd_en && rd_addr < 7'd81) ? board[rd_addr] : 4'($urandom_range(0, 15));

  typedef struct {
    int         done_cyc;
    int         nreads;
    logic       solved;
    logic [4:0] err;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] exp_q[$];
  int         rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference: list cells in row, column, box order; scan until a group
  // repeats a value or holds a value outside 1..9.
  task automatic model_push(input int start_cyc);
    int   order[$];
    int   fail_i;
    bit [9:0] used;
    exp_t e;
    for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) order.push_back(r * 9 + c);
    for (int c = 0; c < 9; c++) for (int r = 0; r < 9; r++) order.push_back(r * 9 + c);
    for (int br = 0; br < 3; br++)
      for (int bc = 0; bc < 3; bc++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) order.push_back((br * 3 + r) * 9 + bc * 3 + c);
    fail_i = -1;
    used = '0;
    for (int i = 0; i < 243; i++) begin
      int v;
      if (i % 9 == 0) used = '0;
      v = int'(board[order[i]]);
      exp_q.push_back(7'(order[i]));
      if (v < 1 || v > 9 || used[v]) begin
        fail_i = i;
        break;
      end
      used[v] = 1'b1;
    end
    if (fail_i < 0) begin
      e.done_cyc = start_cyc + 245; e.nreads = 243; e.solved = 1'b1; e.err = '0;
    end else begin
      e.done_cyc = start_cyc + fail_i + 3; e.nreads = fail_i + 1;
      e.solved = 1'b0; e.err = 5'(fail_i / 9);
    end
    sb_q.push_back(e);
  endtask

  // monitor: every read and every done pulse is matched against the queues
  always @(negedge clka) begin
    if (restart_n) begin
      if (rd_en) begin
        rd_cnt++;
        check("busy_during_read", busy, 1);
        check("read_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rd_addr", rd_addr, exp_q.pop_front());
      end
      if (done) begin
        check("done_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("read_count", rd_cnt, e.nreads);
          check("solved", solved, e.solved);
          check("err_group", err_group, e.err);
          check("busy_at_done", busy, 0);
        end
        rd_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic make_base();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  task automatic make_random();
    int perm[9];
    int j, t, band, r1, r2;
    logic [3:0] tmp;
    for (int i = 0; i < 9; i++) perm[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    make_base();
    for (int i = 0; i < 81; i++) board[i] = 4'(perm[board[i] - 1]);
    band = $urandom_range(0, 2);
    r1 = band * 3 + $urandom_range(0, 2);
    r2 = band * 3 + $urandom_range(0, 2);
    for (int c = 0; c < 9; c++) begin
      tmp = board[r1 * 9 + c]; board[r1 * 9 + c] = board[r2 * 9 + c]; board[r2 * 9 + c] = tmp;
    end
    if ($urandom_range(0, 2) != 0) board[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
  endtask

  task automatic do_start();
    model_push(cyc);
    check_flag = 1'b1;
    @(posedge clka); #1;
    check_flag = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 700) begin
      @(posedge clka); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d expected=0 cycle=%0d", sb_q.size(), cyc);
      sb_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_solved"}, solved, 0);
    check({tag, "_err_group"}, err_group, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // main sequence
  initial begin
    int s;
    restart_n  = 1'b0;
    check_flag = 1'b0;
    make_base();
    repeat (3) @(posedge clka);
    #1;
    check_cleared("reset");
    restart_n = 1'b1;
    @(posedge clka); #1;

    // 1: valid board
    make_base(); do_start(); wait_done();
    // 2: row 4 duplicate at its last cell
    make_base(); board[4 * 9 + 8] = board[4 * 9 + 0]; do_start(); wait_done();
    // 3: swap in row 0, caught by column 0
    make_base(); board[0] = 4'd2; board[1] = 4'd1; do_start(); wait_done();
    // 4: out-of-range and empty cells
    make_base(); board[80] = 4'd10; do_start(); wait_done();
    make_base(); board[0] = 4'd0; do_start(); wait_done();

    // randomized boards
    for (int i = 0; i < 10; i++) begin
      make_random(); do_start(); wait_done();
    end

    // 5: reset in IDLE after a solved pass, then mid-scan
    make_base(); do_start(); wait_done();
    restart_n = 1'b0;
    @(posedge clka); #1;
    check_cleared("idle_reset");
    restart_n = 1'b1;
    do_start();
    repeat (99) @(posedge clka);
    #1;
    restart_n = 1'b0;
    @(posedge clka); #1;
    check_cleared("scan_reset");
    sb_q.delete();
    exp_q.delete();
    rd_cnt = 0;
    restart_n = 1'b1;
    @(posedge clka); #1;
    do_start(); wait_done();

    // 6: check_flag held through a pass, restarts right after REPORT
    make_base();
    s = cyc;
    model_push(s);
    model_push(s + 246);
    check_flag = 1'b1;
    repeat (247) @(posedge clka);
    #1;
    check("restart_solved_cleared", solved, 0);
    check("restart_busy", busy, 1);
    check_flag = 1'b0;
    wait_done();
    repeat (3) @(posedge clka);
    #1;
    check("idle_after_all", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
